// File: rtl/sram_arb_62256.sv
// rtl/sram_arb_62256.sv - two-port round-robin arbiter and wait-state sequencer for a 62256 SRAM
module sram_arb_62256 #(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [14:0] p0_addr,
    input  logic [7:0]  p0_wdata,
    output logic [7:0]  p0_rdata,
    output logic        p0_ack,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [14:0] p1_addr,
    input  logic [7:0]  p1_wdata,
    output logic [7:0]  p1_rdata,
    output logic        p1_ack,
    output logic        sram_csN,
    output logic        sram_oeN,
    output logic        sram_wrN,
    output logic [14:0] sram_addr,
    inout  wire  [7:0]  sram_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        port_q, port_d;
    logic        rr_q, rr_d;
    logic        cs_n_q, cs_n_d;
    logic        oe_n_q, oe_n_d;
    logic        wr_n_q, wr_n_d;
    logic        drive_q, drive_d;
    logic [14:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  p0_rdata_q, p0_rdata_d;
    logic [7:0]  p1_rdata_q, p1_rdata_d;
    logic        p0_ack_q, p0_ack_d;
    logic        p1_ack_q, p1_ack_d;
    logic        grant_sel;
    logic        grant_we;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        port_d     = port_q;
        rr_d       = rr_q;
        cs_n_d     = cs_n_q;
        oe_n_d     = oe_n_q;
        wr_n_d     = wr_n_q;
        drive_d    = drive_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        p0_ack_d   = 1'b0;
        p1_ack_d   = 1'b0;
        // On contention the port that did not win last time is chosen.
        grant_sel  = (p0_req && p1_req) ? ~rr_q : p1_req;
        grant_we   = grant_sel ? p1_we : p0_we;

        case (state_q)
            IDLE: begin
                cs_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                drive_d = 1'b0;
                if (p0_req || p1_req) begin
                    port_d  = grant_sel;
                    rr_d    = grant_sel;
                    addr_d  = grant_sel ? p1_addr : p0_addr;
                    wdata_d = grant_sel ? p1_wdata : p0_wdata;
                    cs_n_d  = 1'b0;
                    if (grant_we) begin
                        state_d = WR_SETUP;
                        cnt_d   = WR_LOAD;
                        drive_d = 1'b1;
                    end else begin
                        state_d = RD;
                        cnt_d   = RD_LOAD;
                        oe_n_d  = 1'b0;
                    end
                end
            end
            RD: begin
                if (cnt_q == 4'd0) begin
                    if (port_q) p1_rdata_d = sram_data;
                    else        p0_rdata_d = sram_data;
                    p0_ack_d = ~port_q;
                    p1_ack_d = port_q;
                    cs_n_d   = 1'b1;
                    oe_n_d   = 1'b1;
                    state_d  = RD_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_DONE: state_d = IDLE;
            WR_SETUP: begin
                wr_n_d  = 1'b0;
                state_d = WR_PULSE;
            end
            WR_PULSE: begin
                if (cnt_q == 4'd0) begin
                    // Rising wrN commits the byte; cs/addr/data stay put one more cycle.
                    wr_n_d   = 1'b1;
                    p0_ack_d = ~port_q;
                    p1_ack_d = port_q;
                    state_d  = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_HOLD: begin
                cs_n_d  = 1'b1;
                drive_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                cs_n_d  = 1'b1;
                oe_n_d  = 1'b1;
                wr_n_d  = 1'b1;
                drive_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            port_q     <= 1'b0;
            rr_q       <= 1'b1;
            cs_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            drive_q    <= 1'b0;
            addr_q     <= 15'd0;
            wdata_q    <= 8'd0;
            p0_rdata_q <= 8'd0;
            p1_rdata_q <= 8'd0;
            p0_ack_q   <= 1'b0;
            p1_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            port_q     <= port_d;
            rr_q       <= rr_d;
            cs_n_q     <= cs_n_d;
            oe_n_q     <= oe_n_d;
            wr_n_q     <= wr_n_d;
            drive_q    <= drive_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            p0_ack_q   <= p0_ack_d;
            p1_ack_q   <= p1_ack_d;
        end
    end

    assign sram_csN  = cs_n_q;
    assign sram_oeN  = oe_n_q;
    assign sram_wrN  = wr_n_q;
    assign sram_addr = addr_q;
    assign sram_data = drive_q ? wdata_q : 8'hzz;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;

endmodule
